inst_encoder: RTL and testbench

Pipelined RISC-V RV32I instruction encoder: packs opcode, register indices, funct fields and a 32-bit signed immediate into a 32-bit instruction word. It is the inverse of `Imm_gen`: it scatters the immediate into the R/I/S/B/U/J bit positions that `Imm_gen` gathers from. It sits between the self-test/program-load sequencer and instruction memory, and uses a valid/ready handshake on both sides with full backpressure.

---
 rtl/inst_encoder.sv | 164 ++++++++++++++++
 tb/tb_inst_encoder.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_encoder.sv
// Two-stage RV32I instruction encoder with valid/ready handshake on both sides.
// Define INST_ENC_RANGE_CHECK_EN to enable immediate range/alignment checking.
module inst_encoder #(
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [2:0]              fmt,
    input  logic [6:0]              opcode,
    input  logic [4:0]              rd,
    input  logic [4:0]              rs1,
    input  logic [4:0]              rs2,
    input  logic [2:0]              funct3,
    input  logic [6:0]              funct7,
    input  logic signed [31:0]      imm,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [31:0]             inst_code,
    output logic                    out_err,
    output logic [CNT_W-1:0]        err_cnt
);

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    function automatic logic fmt_illegal(input logic [2:0] f);
        return f > 3'd5;
    endfunction

`ifdef INST_ENC_RANGE_CHECK_EN
    function automatic logic range_err(input logic [2:0] f, input logic signed [31:0] v);
        logic e;
        e = 1'b0;
        case (f)
            FMT_I, FMT_S: e = (v < -32'sd2048) || (v > 32'sd2047);
            FMT_B:        e = (v < -32'sd4096) || (v > 32'sd4094) || v[0];
            FMT_U:        e = (v[11:0] != 12'd0);
            FMT_J:        e = (v < -32'sd1048576) || (v > 32'sd1048574) || v[0];
            default:      e = 1'b0;
        endcase
        return e;
    endfunction
`endif

    function automatic logic [31:0] pack(
        input logic [2:0]         f,
        input logic [6:0]         op,
        input logic [4:0]         rd_v,
        input logic [4:0]         rs1_v,
        input logic [4:0]         rs2_v,
        input logic [2:0]         f3,
        input logic [6:0]         f7,
        input logic signed [31:0] v
    );
        logic [31:0] w;
        w = 32'h0;
        case (f)
            FMT_R:   w = {f7, rs2_v, rs1_v, f3, rd_v, op};
            FMT_I:   w = {v[11:0], rs1_v, f3, rd_v, op};
            FMT_S:   w = {v[11:5], rs2_v, rs1_v, f3, v[4:0], op};
            FMT_B:   w = {v[12], v[10:5], rs2_v, rs1_v, f3, v[4:1], v[11], op};
            FMT_U:   w = {v[31:12], rd_v, op};
            FMT_J:   w = {v[20], v[10:1], v[11], v[19:12], rd_v, op};
            default: w = 32'h0;
        endcase
        return w;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    logic                    s1_valid_q, s1_valid_d;
    logic [2:0]              s1_fmt_q;
    logic [6:0]              s1_opcode_q;
    logic [4:0]              s1_rd_q, s1_rs1_q, s1_rs2_q;
    logic [2:0]              s1_funct3_q;
    logic [6:0]              s1_funct7_q;
    logic signed [31:0]      s1_imm_q;
    logic                    s1_err_q;

    logic                    s2_valid_q, s2_valid_d;
    logic [31:0]             inst_code_q, inst_code_d;
    logic                    out_err_q, out_err_d;
    logic [CNT_W-1:0]        err_cnt_q, err_cnt_d;

    logic                    s2_load;
    logic                    req_err;

    assign s2_load  = !s2_valid_q || out_ready;
    assign in_ready = !s1_valid_q || s2_load;

`ifdef INST_ENC_RANGE_CHECK_EN
    assign req_err = fmt_illegal(fmt) || range_err(fmt, imm);
`else
    assign req_err = fmt_illegal(fmt);
`endif

    always_comb begin
        s1_valid_d  = s1_valid_q;
        s2_valid_d  = s2_valid_q;
        inst_code_d = inst_code_q;
        out_err_d   = out_err_q;
        err_cnt_d   = err_cnt_q;
        if (in_ready)
            s1_valid_d = in_valid;
        if (s2_load)
            s2_valid_d = s1_valid_q;
        // Data only moves with a real item so the output word stays at its reset value until then.
        if (s2_load && s1_valid_q) begin
            inst_code_d = pack(s1_fmt_q, s1_opcode_q, s1_rd_q, s1_rs1_q, s1_rs2_q,
                               s1_funct3_q, s1_funct7_q, s1_imm_q);
            out_err_d   = s1_err_q;
        end
        if (s2_valid_q && out_ready && out_err_q)
            err_cnt_d = sat_inc(err_cnt_q);
    end

    // Stage 1: capture request fields and the error verdict
    always_ff @(posedge clk) begin
        if (in_ready && in_valid) begin
            s1_fmt_q    <= fmt;
            s1_opcode_q <= opcode;
            s1_rd_q     <= rd;
            s1_rs1_q    <= rs1;
            s1_rs2_q    <= rs2;
            s1_funct3_q <= funct3;
            s1_funct7_q <= funct7;
            s1_imm_q    <= imm;
            s1_err_q    <= req_err;
        end
    end

    // Stage 2: packed word, error flag and the hand-off counter
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            s2_valid_q  <= 1'b0;
            inst_code_q <= 32'h0;
            out_err_q   <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s2_valid_q  <= s2_valid_d;
            inst_code_q <= inst_code_d;
            out_err_q   <= out_err_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign inst_code = inst_code_q;
    assign out_err   = out_err_q;
    assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_inst_encoder.sv
// Bench for inst_encoder: directed test-plan steps, backpressure, mid-stream reset and
// a randomized run checked against a field-table reference model and an ordered scoreboard.
module tb_inst_encoder;

    localparam int CNT_W = 16;

    logic              clk;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [2:0]        fmt;
    logic [6:0]        opcode;
    logic [4:0]        rd, rs1, rs2;
    logic [2:0]        funct3;
    logic [6:0]        funct7;
    logic [31:0]       imm;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       inst_code;
    logic              out_err;
    logic [CNT_W-1:0]  err_cnt;

    inst_encoder #(.CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .fmt(fmt), .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
        .funct3(funct3), .funct7(funct7), .imm(imm),
        .out_valid(out_valid), .out_ready(out_ready), .inst_code(inst_code),
        .out_err(out_err), .err_cnt(err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] word;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    int          n_assert;
    int          n_fail;
    int          model_cnt;
    bit          last_acc;
    bit          hold_prev;
    logic [31:0] prev_word;
    logic        prev_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] fld(input logic [31:0] v, input int hi, input int lo);
        return (v >> lo) & ((32'd1 << (hi - lo + 1)) - 32'd1);
    endfunction

    // Reference packing: each field is extracted by position and shifted to its slot.
    function automatic logic [31:0] ref_word(input int f, input logic [31:0] op, input logic [31:0] d,
                                             input logic [31:0] r1, input logic [31:0] r2,
                                             input logic [31:0] f3, input logic [31:0] f7,
                                             input logic [31:0] v);
        case (f)
            0: return op + (d << 7) + (f3 << 12) + (r1 << 15) + (r2 << 20) + (f7 << 25);
            1: return op + (d << 7) + (f3 << 12) + (r1 << 15) + (fld(v, 11, 0) << 20);
            2: return op + (fld(v, 4, 0) << 7) + (f3 << 12) + (r1 << 15) + (r2 << 20)
                      + (fld(v, 11, 5) << 25);
            3: return op + (fld(v, 11, 11) << 7) + (fld(v, 4, 1) << 8) + (f3 << 12) + (r1 << 15)
                      + (r2 << 20) + (fld(v, 10, 5) << 25) + (fld(v, 12, 12) << 31);
            4: return op + (d << 7) + (v & 32'hFFFF_F000);
            5: return op + (d << 7) + (fld(v, 19, 12) << 12) + (fld(v, 11, 11) << 20)
                      + (fld(v, 10, 1) << 21) + (fld(v, 20, 20) << 31);
            default: return 32'h0;
        endcase
    endfunction

    function automatic logic ref_err(input int f, input logic [31:0] v);
        int si;
        si = int'(v);
        if (f > 5) return 1'b1;
`ifdef INST_ENC_RANGE_CHECK_EN
        case (f)
            1, 2: return (si < -2048) || (si > 2047);
            3:    return (si < -4096) || (si > 4094) || (si % 2 != 0);
            4:    return (v & 32'hFFF) != 32'h0;
            5:    return (si < -1048576) || (si > 1048574) || (si % 2 != 0);
            default: return 1'b0;
        endcase
`else
        return 1'b0;
`endif
    endfunction

    // One clock: observe handshakes at the falling edge, then advance past the rising edge.
    task automatic step();
        exp_t e;
        bit   hand;
        @(negedge clk);
        last_acc = in_valid && in_ready && !rst;
        hand     = out_valid && out_ready && !rst;
        if (!rst) begin
            chk("err_cnt", 32'(err_cnt), 32'(model_cnt));
            if (hold_prev && out_valid) begin
                chk("stall_word", inst_code, prev_word);
                chk("stall_err", 32'(out_err), 32'(prev_err));
            end
            if (hand) begin
                if (sb.size() == 0) begin
                    chk("spurious_out", 32'(out_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("word", inst_code, e.word);
                    chk("err", 32'(out_err), 32'(e.err));
                    if (e.err && model_cnt < (1 << CNT_W) - 1) model_cnt++;
                end
            end
            if (last_acc) begin
                e.word = ref_word(int'(fmt), 32'(opcode), 32'(rd), 32'(rs1), 32'(rs2),
                                  32'(funct3), 32'(funct7), imm);
                e.err  = ref_err(int'(fmt), imm);
                sb.push_back(e);
            end
        end
        hold_prev = out_valid && !out_ready && !rst;
        prev_word = inst_code;
        prev_err  = out_err;
        @(posedge clk);
        if (rst) begin
            sb.delete();
            model_cnt = 0;
            hold_prev = 1'b0;
        end
        #1;
    endtask

    task automatic set_req(input int f, input int op, input int d, input int r1, input int r2,
                           input int f3, input int f7, input logic [31:0] v);
        fmt = 3'(f); opcode = 7'(op); rd = 5'(d); rs1 = 5'(r1); rs2 = 5'(r2);
        funct3 = 3'(f3); funct7 = 7'(f7); imm = v;
        in_valid = 1'b1;
    endtask

    // Offer a request and hold it until accepted, within a cycle budget.
    task automatic send(input int f, input int op, input int d, input int r1, input int r2,
                        input int f3, input int f7, input logic [31:0] v);
        int n;
        set_req(f, op, d, r1, r2, f3, f7, v);
        n = 0;
        do begin
            step();
            n++;
        end while (!last_acc && n < 50);
        if (!last_acc) chk("accept_timeout", 32'd0, 32'd1);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        out_ready = 1'b1;
        n = 0;
        while ((sb.size() > 0 || out_valid) && n < 60) begin
            step();
            n++;
        end
        chk("drain_empty", 32'(sb.size()), 32'd0);
    endtask

    function automatic logic [31:0] pick_imm();
        case ($urandom_range(0, 9))
            0: return $urandom;
            1: return 32'($urandom_range(0, 4095)) - 32'd2048;
            2: return 32'($urandom_range(0, 16)) - 32'd2056;
            3: return 32'($urandom_range(0, 16)) + 32'd2040;
            4: return 32'($urandom_range(0, 8)) + 32'd4090;
            5: return 32'($urandom_range(0, 8)) - 32'd4100;
            6: return 32'($urandom_range(0, 8)) + 32'd1048570;
            7: return 32'($urandom_range(0, 8)) - 32'd1048580;
            8: return $urandom & 32'hFFFF_F000;
            default: return 32'($urandom_range(0, 63));
        endcase
    endfunction

    initial begin
        n_assert = 0; n_fail = 0; model_cnt = 0; hold_prev = 1'b0; last_acc = 1'b0;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        set_req(0, 0, 0, 0, 0, 0, 0, 32'h0);
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_inst_code", inst_code, 32'h0);
        chk("rst_out_err", 32'(out_err), 32'd0);
        chk("rst_err_cnt", 32'(err_cnt), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);

        // addi x1,x0,5 with latency check
        send(1, 'h13, 1, 0, 0, 0, 0, 32'd5);
        chk("addi_lat1", 32'(out_valid), 32'd0);
        step();
        chk("addi_lat2", 32'(out_valid), 32'd1);
        chk("addi_word", inst_code, 32'h0050_0093);
        chk("addi_err", 32'(out_err), 32'd0);
        step();

        // sw / beq / jal back-to-back
        set_req(2, 'h23, 0, 1, 2, 2, 0, 32'd4);  step();
        set_req(3, 'h63, 0, 0, 0, 0, 0, 32'd8);  step();
        chk("b2b_v0", 32'(out_valid), 32'd1);
        chk("b2b_sw", inst_code, 32'h0020_A223);
        set_req(5, 'h6F, 1, 0, 0, 0, 0, 32'd2048); step();
        in_valid = 1'b0;
        chk("b2b_v1", 32'(out_valid), 32'd1);
        chk("b2b_beq", inst_code, 32'h0000_0463);
        step();
        chk("b2b_v2", 32'(out_valid), 32'd1);
        chk("b2b_jal", inst_code, 32'h0010_00EF);
        drain();

        // lui, misaligned lui, out-of-range addi, odd branch, illegal fmt
        send(4, 'h37, 5, 0, 0, 0, 0, 32'h1234_5000);
        step();
        chk("lui_word", inst_code, 32'h1234_52B7);
        chk("lui_err", 32'(out_err), 32'd0);
        send(4, 'h37, 5, 0, 0, 0, 0, 32'h1234_5001);
        send(1, 'h13, 1, 0, 0, 0, 0, 32'd2048);
        send(3, 'h63, 0, 1, 2, 0, 0, 32'd3);
        send(6, 'h13, 1, 2, 3, 4, 5, 32'd0);
        drain();
        step();
        chk("illegal_word", inst_code, 32'h0);
        chk("illegal_err", 32'(out_err), 32'd1);

        // Backpressure with three requests offered
        out_ready = 1'b0;
        set_req(0, 'h33, 3, 4, 5, 0, 'h20, 32'h0); step();
        chk("bp_acc0", 32'(last_acc), 32'd1);
        set_req(1, 'h13, 6, 7, 0, 1, 0, 32'hFFFF_FFFF); step();
        chk("bp_acc1", 32'(last_acc), 32'd1);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        set_req(2, 'h23, 0, 8, 9, 2, 0, 32'hFFFF_F800); step();
        chk("bp_acc2", 32'(last_acc), 32'd0);
        step(); step();
        chk("bp_held_valid", 32'(out_valid), 32'd1);
        out_ready = 1'b1;
        send(2, 'h23, 0, 8, 9, 2, 0, 32'hFFFF_F800);
        drain();

        // Randomized traffic with random backpressure
        for (int i = 0; i < 400; i++) begin
            if (!in_valid && $urandom_range(0, 3) != 0)
                set_req($urandom_range(0, 7), $urandom_range(0, 127), $urandom_range(0, 31),
                        $urandom_range(0, 31), $urandom_range(0, 31), $urandom_range(0, 7),
                        $urandom_range(0, 127), pick_imm());
            out_ready = ($urandom_range(0, 3) != 0);
            step();
            if (last_acc) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        drain();

        // Mid-stream reset with errored items in flight
        out_ready = 1'b0;
        send(6, 'h13, 0, 0, 0, 0, 0, 32'h0);
        send(7, 'h13, 0, 0, 0, 0, 0, 32'h0);
        chk("pre_rst_cnt_nz", 32'(err_cnt != 0), 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_cnt", 32'(err_cnt), 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("post_rst_quiet", 32'(out_valid), 32'd0);
        end
        send(1, 'h13, 1, 0, 0, 0, 0, 32'd5);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
